xor_frame_checksum: RTL and testbench



---
 rtl/xor_chk_pkg.sv | 13 +
 rtl/xor_reduce.sv | 31 +++
 rtl/xor_frame_checksum.sv | 139 +++++++++++++
 tb/tb_xor_frame_checksum.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/xor_chk_pkg.sv
// Shared types and default sizing for the XOR frame checksum block.
package xor_chk_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MAX_LEN = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_e;

endpackage

// File: rtl/xor_reduce.sv
// Parametrised XOR reduction built as a balanced binary tree.
module xor_reduce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic             red_c
);

  if (WIDTH == 1) begin : g_leaf
    assign red_c = in_bits[0];
  end else begin : g_split
    localparam int unsigned LO_W = WIDTH / 2;
    localparam int unsigned HI_W = WIDTH - LO_W;

    logic lo_c;
    logic hi_c;

    xor_reduce #(.WIDTH(LO_W)) u_lo (
      .in_bits (in_bits[LO_W-1:0]),
      .red_c   (lo_c)
    );

    xor_reduce #(.WIDTH(HI_W)) u_hi (
      .in_bits (in_bits[WIDTH-1:LO_W]),
      .red_c   (hi_c)
    );

    assign red_c = lo_c ^ hi_c;
  end

endmodule

// File: rtl/xor_frame_checksum.sv
// Accumulates the XOR of every beat in a frame, counts beats (saturating) and
// optionally checks the result against an expected checksum.
module xor_frame_checksum
  import xor_chk_pkg::*;
#(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             verify,
  input  logic [WIDTH-1:0] exp_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_len,
  output logic             out_err,
  output logic             out_ovf
);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             verify_q, verify_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             beat_c;
  logic             take_c;
  logic [WIDTH-1:0] sum_nxt_c;
  logic             verify_eff_c;

  // First beat of a frame starts a fresh sum and uses the live verify flag.
  always_comb begin
    beat_c       = in_valid && in_ready_q;
    take_c       = out_valid_q && out_ready;
    sum_nxt_c    = (state_q == ST_IDLE) ? in_data : (sum_q ^ in_data);
    verify_eff_c = (state_q == ST_IDLE) ? verify : verify_q;
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    len_d       = len_q;
    verify_d    = verify_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (beat_c) begin
          sum_d    = sum_nxt_c;
          len_d    = CNT_W'(1);
          verify_d = verify;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat_c) begin
          sum_d = sum_nxt_c;
          if (len_q == CNT_W'(MAX_LEN)) begin
            ovf_d = 1'b1;
          end else begin
            len_d = len_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (take_c) begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    // Last beat closes the frame and resolves the compare on the final sum.
    if (beat_c && in_last) begin
      state_d     = ST_DONE;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b1;
      err_d       = verify_eff_c && (sum_nxt_c != exp_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      len_q       <= '0;
      verify_q    <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      verify_q    <= verify_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  xor_reduce #(.WIDTH(WIDTH)) u_parity (
    .in_bits (sum_q),
    .red_c   (out_parity)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_len   = len_q;
  assign out_err   = err_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Randomised and directed bench; two instances (MAX_LEN 256 and 4) share stimulus.
module tb_xor_frame_checksum;

  localparam int unsigned W      = 8;
  localparam int unsigned MAX_A  = 256;
  localparam int unsigned MAX_B  = 4;
  localparam int unsigned CW_A   = $clog2(MAX_A + 1);
  localparam int unsigned CW_B   = $clog2(MAX_B + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          verify;
  logic [W-1:0]  exp_sum;
  logic          out_ready;

  logic          a_in_ready, a_out_valid, a_out_parity, a_out_err, a_out_ovf;
  logic [W-1:0]  a_out_sum;
  logic [CW_A-1:0] a_out_len;
  logic          b_in_ready, b_out_valid, b_out_parity, b_out_err, b_out_ovf;
  logic [W-1:0]  b_out_sum;
  logic [CW_B-1:0] b_out_len;

  int n_chk = 0;
  int n_bad = 0;

  logic [W-1:0] frm[$];

  always #5 clk = ~clk;

  xor_frame_checksum #(.WIDTH(W), .MAX_LEN(MAX_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .verify(verify), .exp_sum(exp_sum),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_parity(a_out_parity), .out_len(a_out_len), .out_err(a_out_err),
    .out_ovf(a_out_ovf)
  );

  xor_frame_checksum #(.WIDTH(W), .MAX_LEN(MAX_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .verify(verify), .exp_sum(exp_sum),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_parity(b_out_parity), .out_len(b_out_len), .out_err(b_out_err),
    .out_ovf(b_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h @%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-frame XOR, beat count clipped at the limit, compare on demand.
  task automatic check_result(input string tag, input logic vfy, input logic [W-1:0] exp);
    logic [W-1:0] xs;
    int n;
    xs = '0;
    foreach (frm[i]) xs ^= frm[i];
    n = frm.size();
    chk({tag, ".a.vld"}, 32'(a_out_valid), 32'd1);
    chk({tag, ".a.rdy"}, 32'(a_in_ready), 32'd0);
    chk({tag, ".a.sum"}, 32'(a_out_sum), 32'(xs));
    chk({tag, ".a.par"}, 32'(a_out_parity), 32'(^xs));
    chk({tag, ".a.len"}, 32'(a_out_len), 32'((n > int'(MAX_A)) ? int'(MAX_A) : n));
    chk({tag, ".a.ovf"}, 32'(a_out_ovf), 32'(n > int'(MAX_A)));
    chk({tag, ".a.err"}, 32'(a_out_err), 32'(vfy && (xs != exp)));
    chk({tag, ".b.vld"}, 32'(b_out_valid), 32'd1);
    chk({tag, ".b.sum"}, 32'(b_out_sum), 32'(xs));
    chk({tag, ".b.par"}, 32'(b_out_parity), 32'(^xs));
    chk({tag, ".b.len"}, 32'(b_out_len), 32'((n > int'(MAX_B)) ? int'(MAX_B) : n));
    chk({tag, ".b.ovf"}, 32'(b_out_ovf), 32'(n > int'(MAX_B)));
    chk({tag, ".b.err"}, 32'(b_out_err), 32'(vfy && (xs != exp)));
  endtask

  // Drive frm with random idle gaps, then hold the result for 'hold' cycles.
  task automatic run_frame(input string tag, input logic vfy, input logic [W-1:0] exp,
                           input int gap_max, input int hold);
    for (int i = 0; i < frm.size(); i++) begin
      int gap;
      gap = $urandom_range(0, gap_max);
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'b0;
      verify   = 1'($urandom);
      for (int g = 0; g < gap; g++) step();
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = (i == frm.size() - 1);
      verify   = (i == 0) ? vfy : 1'($urandom);
      exp_sum  = (i == frm.size() - 1) ? exp : W'($urandom);
      chk({tag, ".acc_rdy"}, 32'(a_in_ready && b_in_ready), 32'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_sum  = W'($urandom);
    verify   = 1'($urandom);
    check_result(tag, vfy, exp);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check_result({tag, ".hold"}, vfy, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".take.vld"}, 32'(a_out_valid || b_out_valid), 32'd0);
    chk({tag, ".take.rdy"}, 32'(a_in_ready && b_in_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".a.rdy"}, 32'(a_in_ready), 32'd1);
    chk({tag, ".a.vld"}, 32'(a_out_valid), 32'd0);
    chk({tag, ".a.sum"}, 32'(a_out_sum), 32'd0);
    chk({tag, ".a.len"}, 32'(a_out_len), 32'd0);
    chk({tag, ".a.err"}, 32'(a_out_err), 32'd0);
    chk({tag, ".a.ovf"}, 32'(a_out_ovf), 32'd0);
    chk({tag, ".b.rdy"}, 32'(b_in_ready), 32'd1);
    chk({tag, ".b.vld"}, 32'(b_out_valid), 32'd0);
    chk({tag, ".b.sum"}, 32'(b_out_sum), 32'd0);
    chk({tag, ".b.len"}, 32'(b_out_len), 32'd0);
  endtask

  initial begin
    logic [W-1:0] xs;
    logic         vfy;
    logic [W-1:0] exp;
    int           n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    verify    = 1'b0;
    exp_sum   = '0;
    out_ready = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    frm = '{8'h12, 8'h34, 8'h56};
    run_frame("three", 1'b0, 8'h00, 0, 0);
    chk("three.const_sum", 32'(8'h12 ^ 8'h34 ^ 8'h56), 32'h70);

    frm = '{8'hA5};
    run_frame("single", 1'b1, 8'hA5, 0, 0);

    frm = '{8'hFF, 8'h0F};
    run_frame("err", 1'b1, 8'h00, 0, 0);

    frm = '{8'h3C, 8'h11, 8'h80};
    run_frame("stall", 1'b1, 8'h3C ^ 8'h11 ^ 8'h80, 0, 5);

    frm = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_frame("ovf", 1'b0, 8'h00, 1, 1);

    // Reset mid-frame after two beats, colliding with a third beat.
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b0; verify = 1'b1;
    step();
    in_data = 8'hC3;
    step();
    in_data = 8'h77;
    rst_n   = 1'b0;
    step();
    in_valid = 1'b0;
    check_reset_vals("midrst");
    rst_n = 1'b1;
    frm = '{8'h33};
    run_frame("post_rst", 1'b0, 8'h00, 0, 0);

    for (int f = 0; f < 25; f++) begin
      frm.delete();
      n = $urandom_range(1, 9);
      xs = '0;
      for (int i = 0; i < n; i++) begin
        frm.push_back(W'($urandom));
        xs ^= frm[i];
      end
      vfy = 1'($urandom);
      exp = ($urandom_range(0, 1) == 0) ? xs : W'($urandom);
      run_frame($sformatf("rnd%0d", f), vfy, exp, 2, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
